// File: rtl/au_seq_pkg.sv
// Shared constants for the sequential sign-magnitude arithmetic unit:
// default widths, opcode values and FSM state encoding.
package au_seq_pkg;

    localparam int unsigned AU_DATA_WIDTH   = 16;
    localparam int unsigned AU_MSB          = AU_DATA_WIDTH - 1;
    localparam int unsigned AU_OPCODE_WIDTH = 3;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_MULT = 3;
    localparam int unsigned OP_DIV  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_DONE   = 3'd4
    } au_state_t;

endpackage

// File: rtl/au_seq_iter.sv
// Iterative magnitude engine: MAG-step shift-add multiply or restoring divide
// on one shared {hi, lo} register pair, with its own step counter.
module au_seq_iter #(
    parameter int unsigned MAG = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_div,
    input  logic [MAG-1:0]   a_mag,
    input  logic [MAG-1:0]   b_mag,
    output logic             done,
    output logic [2*MAG-1:0] product,
    output logic [MAG-1:0]   quotient,
    output logic [MAG-1:0]   remainder
);

    localparam int unsigned CNT_W = $clog2(MAG + 1);

    logic             busy;
    logic             is_div;
    logic [CNT_W-1:0] cnt;
    logic [MAG-1:0]   hi;
    logic [MAG-1:0]   lo;
    logic [MAG-1:0]   opnd;
    logic [MAG:0]     mul_sum;
    logic [MAG:0]     div_shift;
    logic [MAG:0]     div_diff;

    // A zero divisor never borrows, so the quotient fills with ones and A
    // shifts through intact into the remainder without a special case.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[MAG-1]};
        div_diff  = div_shift - {1'b0, opnd};
        done      = busy && (cnt == CNT_W'(MAG - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            is_div <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_div <= start_div;
            cnt    <= '0;
            hi     <= '0;
            lo     <= a_mag;
            opnd   <= b_mag;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CNT_W'(1);
            end
            if (is_div) begin
                if (!div_diff[MAG]) begin
                    hi <= div_diff[MAG-1:0];
                    lo <= {lo[MAG-2:0], 1'b1};
                end else begin
                    hi <= div_shift[MAG-1:0];
                    lo <= {lo[MAG-2:0], 1'b0};
                end
            end else begin
                {hi, lo} <= {mul_sum, lo[MAG-1:1]};
            end
        end
    end

    assign product   = {hi, lo};
    assign quotient  = lo;
    assign remainder = hi;

endmodule

// File: rtl/au_seq.sv
// Sequential sign-magnitude arithmetic unit: ADD/SUB in one step, MULT/DIV
// via the iterative engine, valid/ready handshake and registered results.
module au_seq
    import au_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = AU_DATA_WIDTH,
    parameter int unsigned OPCODE_WIDTH = AU_OPCODE_WIDTH
) (
    input  logic                    Global_clk,
    input  logic                    Global_reset,
    input  logic                    AU_op_valid,
    output logic                    AU_op_ready,
    input  logic [OPCODE_WIDTH-1:0] Mode,
    input  logic [DATA_WIDTH-1:0]   AU_in_1,
    input  logic [DATA_WIDTH-1:0]   AU_in_2,
    output logic [DATA_WIDTH-1:0]   AU_out,
    output logic [DATA_WIDTH-1:0]   AU_rem_out,
    output logic                    AU_out_valid,
    output logic                    AU_overflow,
    output logic                    AU_div_by_zero
);

    localparam int unsigned MSB = DATA_WIDTH - 1;
    localparam int unsigned MAG = DATA_WIDTH - 1;

    au_state_t               state;
    logic [OPCODE_WIDTH-1:0] mode_r;
    logic [DATA_WIDTH-1:0]   a_r;
    logic [DATA_WIDTH-1:0]   b_r;

    logic                    accept;
    logic                    iter_start;
    logic                    iter_done;
    logic [2*MAG-1:0]        product;
    logic [MAG-1:0]          quotient;
    logic [MAG-1:0]          remainder;

    logic                    is_add, is_sub, is_mul, is_div;
    logic                    a_sign, b_sign;
    logic [MAG-1:0]          a_mag, b_mag;
    logic [MAG:0]            add_sum;
    logic [MAG-1:0]          nxt_mag;
    logic                    nxt_sign;
    logic [DATA_WIDTH-1:0]   nxt_out;
    logic [DATA_WIDTH-1:0]   nxt_rem;
    logic                    nxt_ovf;
    logic                    nxt_dbz;

    assign AU_op_ready = (state == S_IDLE);
    assign accept      = AU_op_ready && AU_op_valid;
    assign iter_start  = accept && ((Mode == OPCODE_WIDTH'(OP_MULT)) ||
                                    (Mode == OPCODE_WIDTH'(OP_DIV)));

    au_seq_iter #(
        .MAG (MAG)
    ) u_iter (
        .clk       (Global_clk),
        .rst       (Global_reset),
        .start     (iter_start),
        .start_div (Mode == OPCODE_WIDTH'(OP_DIV)),
        .a_mag     (AU_in_1[MAG-1:0]),
        .b_mag     (AU_in_2[MAG-1:0]),
        .done      (iter_done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        is_add  = (mode_r == OPCODE_WIDTH'(OP_ADD));
        is_sub  = (mode_r == OPCODE_WIDTH'(OP_SUB));
        is_mul  = (mode_r == OPCODE_WIDTH'(OP_MULT));
        is_div  = (mode_r == OPCODE_WIDTH'(OP_DIV));
        a_sign  = a_r[MSB];
        b_sign  = b_r[MSB];
        a_mag   = a_r[MAG-1:0];
        b_mag   = b_r[MAG-1:0];
        add_sum = {1'b0, a_mag} + {1'b0, b_mag};
        nxt_mag  = '0;
        nxt_sign = 1'b0;
        nxt_rem  = '0;
        nxt_ovf  = 1'b0;
        nxt_dbz  = 1'b0;
        if (is_mul) begin
            nxt_mag  = product[MAG-1:0];
            nxt_sign = a_sign ^ b_sign;
            nxt_ovf  = |product[2*MAG-1:MAG];
        end else if (is_div) begin
            nxt_mag  = quotient;
            nxt_sign = a_sign ^ b_sign;
            nxt_dbz  = (b_mag == '0);
            nxt_rem  = {a_sign && (|remainder), remainder};
        end else if ((a_sign == (b_sign ^ is_sub)) && (is_add || is_sub)) begin
            nxt_mag  = add_sum[MAG-1:0];
            nxt_sign = a_sign;
            nxt_ovf  = add_sum[MAG];
        end else if (a_mag >= b_mag) begin
            nxt_mag  = a_mag - b_mag;
            nxt_sign = a_sign;
        end else begin
            nxt_mag  = b_mag - a_mag;
            nxt_sign = b_sign ^ is_sub;
        end
        nxt_out = {nxt_sign && (|nxt_mag), nxt_mag};
    end

    always_ff @(posedge Global_clk or posedge Global_reset) begin
        if (Global_reset) begin
            state          <= S_IDLE;
            mode_r         <= '0;
            a_r            <= '0;
            b_r            <= '0;
            AU_out         <= '0;
            AU_rem_out     <= '0;
            AU_out_valid   <= 1'b0;
            AU_overflow    <= 1'b0;
            AU_div_by_zero <= 1'b0;
        end else begin
            AU_out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_r <= Mode;
                        a_r    <= AU_in_1;
                        b_r    <= AU_in_2;
                        if ((Mode == OPCODE_WIDTH'(OP_ADD)) || (Mode == OPCODE_WIDTH'(OP_SUB)))
                            state <= S_ADDSUB;
                        else if (Mode == OPCODE_WIDTH'(OP_MULT))
                            state <= S_MUL;
                        else if (Mode == OPCODE_WIDTH'(OP_DIV))
                            state <= S_DIV;
                        else
                            state <= S_DONE;
                    end
                end
                S_ADDSUB: state <= S_DONE;
                S_MUL, S_DIV: begin
                    if (iter_done)
                        state <= S_DONE;
                end
                S_DONE: begin
                    AU_out_valid   <= 1'b1;
                    AU_overflow    <= nxt_ovf;
                    AU_div_by_zero <= nxt_dbz;
                    // NOP and undefined codes leave the data outputs untouched.
                    if (is_add || is_sub || is_mul || is_div) begin
                        AU_out     <= nxt_out;
                        AU_rem_out <= nxt_rem;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_seq.sv
// Directed bench for au_seq: vector table of single ops with hand-computed
// results and latencies, plus reset-abort and busy-valid sequences.
module tb_au_seq;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  mode;
    logic [15:0] in_1;
    logic [15:0] in_2;
    logic [15:0] out;
    logic [15:0] rem_out;
    logic        out_valid;
    logic        overflow;
    logic        div_by_zero;

    int unsigned n_cmp;
    int unsigned n_bad;

    au_seq #(
        .DATA_WIDTH   (16),
        .OPCODE_WIDTH (3)
    ) dut (
        .Global_clk     (clk),
        .Global_reset   (rst),
        .AU_op_valid    (op_valid),
        .AU_op_ready    (op_ready),
        .Mode           (mode),
        .AU_in_1        (in_1),
        .AU_in_2        (in_2),
        .AU_out         (out),
        .AU_rem_out     (rem_out),
        .AU_out_valid   (out_valid),
        .AU_overflow    (overflow),
        .AU_div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [15:0] rem;
        logic        ovf;
        logic        dbz;
        int unsigned lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_result(output int unsigned lat, output logic busy_ready);
        lat = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && op_ready)
                busy_ready = 1'b1;
        end while (!out_valid && lat < 40);
    endtask

    task automatic do_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                         output int unsigned lat, output logic busy_ready);
        int unsigned w;
        @(negedge clk);
        w = 0;
        while (!op_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!op_ready)
            check("ready_wait", 32'(op_ready), 32'd1);
        mode     = m;
        in_1     = a;
        in_2     = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        in_1 = 16'h5A5A;
        in_2 = 16'hA5A5;
        wait_result(lat, busy_ready);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned lat;
        logic        busy_ready;
        logic        saw_valid;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{3'd1, 16'h0003, 16'h8002, 16'h0001, 16'h0000, 1'b0, 1'b0, 2};
        vecs[1]  = '{3'd2, 16'h0002, 16'h0005, 16'h8003, 16'h0000, 1'b0, 1'b0, 2};
        vecs[2]  = '{3'd1, 16'h0005, 16'h8005, 16'h0000, 16'h0000, 1'b0, 1'b0, 2};
        vecs[3]  = '{3'd1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
        vecs[4]  = '{3'd3, 16'h012C, 16'h80C8, 16'hEA60, 16'h0000, 1'b1, 1'b0, 16};
        vecs[5]  = '{3'd4, 16'h8064, 16'h0007, 16'h800E, 16'h8002, 1'b0, 1'b0, 16};
        vecs[6]  = '{3'd4, 16'h0009, 16'h8000, 16'hFFFF, 16'h0009, 1'b0, 1'b1, 16};
        vecs[7]  = '{3'd0, 16'h1234, 16'h5678, 16'hFFFF, 16'h0009, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'd2, 16'h8003, 16'h8003, 16'h0000, 16'h0000, 1'b0, 1'b0, 2};
        vecs[9]  = '{3'd3, 16'h8000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 16};
        vecs[10] = '{3'd3, 16'h00FF, 16'h0080, 16'h7F80, 16'h0000, 1'b0, 1'b0, 16};
        vecs[11] = '{3'd3, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 16};
        vecs[12] = '{3'd4, 16'h8007, 16'h8002, 16'h0003, 16'h8001, 1'b0, 1'b0, 16};
        vecs[13] = '{3'd4, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 16};
        vecs[14] = '{3'd1, 16'h8001, 16'h8001, 16'h8002, 16'h0000, 1'b0, 1'b0, 2};
        vecs[15] = '{3'd5, 16'h1111, 16'h2222, 16'h8002, 16'h0000, 1'b0, 1'b0, 1};
        vecs[16] = '{3'd1, 16'hFFFF, 16'h8001, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
        vecs[17] = '{3'd4, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0, 1'b0, 16};
        vecs[18] = '{3'd4, 16'h8003, 16'h0007, 16'h0000, 16'h8003, 1'b0, 1'b0, 16};
        vecs[19] = '{3'd2, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2};

        rst      = 1'b1;
        op_valid = 1'b0;
        mode     = '0;
        in_1     = '0;
        in_2     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(op_ready), 32'd1);
        check("reset_out", 32'(out), 32'd0);
        check("reset_rem", 32'(rem_out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'({overflow, div_by_zero}), 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat, busy_ready);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].out));
            check($sformatf("v%0d_rem", i), 32'(rem_out), 32'(vecs[i].rem));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            if (vecs[i].lat > 1)
                check($sformatf("v%0d_ready_busy", i), 32'(busy_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse_width", i), 32'(out_valid), 32'd0);
        end

        // Reset in the middle of a MULT after a DIV leaves non-zero outputs.
        do_op(3'd4, 16'h8064, 16'h0007, lat, busy_ready);
        check("pre_reset_out", 32'(out), 32'h800E);
        check("pre_reset_rem", 32'(rem_out), 32'h8002);
        @(negedge clk);
        mode     = 3'd3;
        in_1     = 16'h012C;
        in_2     = 16'h80C8;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_out", 32'(out), 32'd0);
        check("midreset_rem", 32'(rem_out), 32'd0);
        check("midreset_flags", 32'({out_valid, overflow, div_by_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid)
                saw_valid = 1'b1;
        end
        check("midreset_no_valid", 32'(saw_valid), 32'd0);
        check("midreset_ready", 32'(op_ready), 32'd1);
        do_op(3'd1, 16'h0001, 16'h0001, lat, busy_ready);
        check("post_reset_lat", lat, 32'd2);
        check("post_reset_out", 32'(out), 32'h0002);

        // Valid held high with new operands while a DIV is in flight.
        @(negedge clk);
        mode     = 3'd4;
        in_1     = 16'h0064;
        in_2     = 16'h0005;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        mode = 3'd1;
        in_1 = 16'h0001;
        in_2 = 16'h0002;
        wait_result(lat, busy_ready);
        check("hold_div_lat", lat, 32'd16);
        check("hold_div_out", 32'(out), 32'h0014);
        check("hold_div_rem", 32'(rem_out), 32'h0000);
        check("hold_div_ready_busy", 32'(busy_ready), 32'd0);
        check("hold_ready_after", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        check("hold_second_accept", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
        wait_result(lat, busy_ready);
        check("hold_add_lat", lat, 32'd2);
        check("hold_add_out", 32'(out), 32'h0003);
        check("hold_add_rem", 32'(rem_out), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
